// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU internal-operation sequencer: op codes,
// FSM states and the active-low {MOV, INC_DEC, DEC} strobe patterns.
package alu_seq_pkg;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit order: {INTERNAL_MOV, INTERNAL_INC_DEC, INTERNAL_DEC}, all active-low.
  localparam logic [2:0] PAT_IDLE = 3'b111;
  localparam logic [2:0] PAT_MOV  = 3'b011;
  localparam logic [2:0] PAT_INC  = 3'b001;
  localparam logic [2:0] PAT_DEC  = 3'b000;

endpackage

// File: rtl/alu_strobe_enc.sv
// Combinational op -> {MOV, INC_DEC, DEC} strobe pattern. The reserved op
// maps to the all-high pattern so an illegal strobe combination can never
// come out of this encoder.
module alu_strobe_enc
  import alu_seq_pkg::*;
(
  input  logic [1:0] op,
  output logic [2:0] pat
);

  // Map each legal op onto its fixed strobe pattern.
  always_comb begin
    pat = PAT_IDLE;
    case (op)
      OP_MOV:  pat = PAT_MOV;
      OP_INC:  pat = PAT_INC;
      OP_DEC:  pat = PAT_DEC;
      default: pat = PAT_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_internal_seq.sv
// ALU internal-operation sequencer. Accepts one request over valid/ready,
// replays the active-low strobe pattern for req_cnt+1 cycles, then pulses
// done (and err for a reserved op). All outputs except req_ready are
// registered. Optional feature macro: ALU_SEQ_ABORT_EN adds an abort input
// that ends a RUN early.
module alu_internal_seq
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_addr,
  input  logic [CNT_W-1:0] req_cnt,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             INTERNAL_MOV,
  output logic             ADDRESS_MODE,
  output logic             INTERNAL_INC_DEC,
  output logic             INTERNAL_DEC,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pat_q, pat_d;
  logic             addr_n_q, addr_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       enc_pat;
  logic             abort_hit;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  alu_strobe_enc u_enc (
    .op  (req_op),
    .pat (enc_pat)
  );

  assign req_ready = (state_q == ST_IDLE);

  // Next-state and next-output decode; the strobe register only ever loads
  // a legal pattern or all-high.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = PAT_IDLE;
    addr_n_d = 1'b1;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_RSVD) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_RUN;
            cnt_d    = req_cnt;
            pat_d    = enc_pat;
            addr_n_d = ~req_addr;
          end
        end
      end
      ST_RUN: begin
        if (abort_hit || (cnt_q == '0)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          pat_d    = pat_q;
          addr_n_d = addr_n_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pat_q    <= PAT_IDLE;
      addr_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      addr_n_q <= addr_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign INTERNAL_MOV     = pat_q[2];
  assign INTERNAL_INC_DEC = pat_q[1];
  assign INTERNAL_DEC     = pat_q[0];
  assign ADDRESS_MODE     = addr_n_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_alu_internal_seq.sv
// Scoreboard bench for alu_internal_seq: each accepted request pushes the
// per-cycle output trace it must produce; a negedge monitor pops and compares.
// Output vector: {MOV, ADDR, INC_DEC, DEC, req_ready, busy, done, err}.
module tb_alu_internal_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       req_addr;
  logic [1:0] req_cnt;
`ifdef ALU_SEQ_ABORT_EN
  logic       abort;
`endif
  logic       INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC;
  logic       busy, done, err;

  typedef struct {
    logic [7:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  localparam logic [7:0] V_IDLE = 8'b1111_1000;
  localparam logic [7:0] V_DONE = 8'b1111_0110;
  localparam logic [7:0] V_ERR  = 8'b1111_0111;

  alu_internal_seq #(.CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_cnt          (req_cnt),
`ifdef ALU_SEQ_ABORT_EN
    .abort            (abort),
`endif
    .INTERNAL_MOV     (INTERNAL_MOV),
    .ADDRESS_MODE     (ADDRESS_MODE),
    .INTERNAL_INC_DEC (INTERNAL_INC_DEC),
    .INTERNAL_DEC     (INTERNAL_DEC),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat_of(input logic [1:0] op);
    case (op)
      2'b00:   return 3'b011;
      2'b01:   return 3'b001;
      2'b10:   return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] v_run(input logic [1:0] op, input logic addr);
    logic [2:0] p;
    p = pat_of(op);
    return {p[2], ~addr, p[1], p[0], 4'b0100};
  endfunction

  function automatic logic [7:0] out_vec();
    return {INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC,
            req_ready, busy, done, err};
  endfunction

  task automatic push(input logic [7:0] vec, input string tag);
    exp_t e;
    e.vec = vec;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Full trace of one accepted op, including the idle cycle that follows DONE.
  task automatic push_op(input logic [1:0] op, input logic addr, input int cnt);
    if (op == 2'b11) begin
      push(V_ERR, "rsvd_done");
    end else begin
      for (int i = 0; i <= cnt; i++) push(v_run(op, addr), $sformatf("run%0d", i));
      push(V_DONE, "done");
    end
    push(V_IDLE, "gap");
  endtask

  // Per-cycle monitor: legality of the strobe code, then the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("legal",
            {31'd0, (INTERNAL_INC_DEC && !INTERNAL_DEC) ||
                    (INTERNAL_MOV && (!INTERNAL_INC_DEC || !INTERNAL_DEC))}, 32'd0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, {24'd0, out_vec()}, {24'd0, e.vec});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic scramble();
    req_op   = 2'($urandom_range(0, 3));
    req_addr = 1'($urandom_range(0, 1));
    req_cnt  = 2'($urandom_range(0, 3));
  endtask

  // Present one request, push its trace on acceptance, then disturb req_*.
  task automatic do_op(input logic [1:0] op, input logic addr, input logic [1:0] cnt);
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_cnt   = cnt;
    @(posedge clk);
    push_op(op, addr, int'(cnt));
    #1;
    req_valid = 1'b0;
    scramble();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 1'b0;
    req_cnt   = 2'b00;
`ifdef ALU_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {24'd0, out_vec()}, {24'd0, V_IDLE});
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single-cycle MOV, then a full-length DEC in address mode.
    do_op(2'b00, 1'b0, 2'd0);
    drain();
    do_op(2'b10, 1'b1, 2'd3);
    drain();

    // Request held valid; a different op presented while busy is taken only
    // once the sequencer is back in IDLE.
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 1'b0;
    req_cnt   = 2'd1;
    @(posedge clk);
    push_op(2'b01, 1'b0, 1);
    #1;
    req_op   = 2'b10;
    req_addr = 1'b1;
    req_cnt  = 2'd0;
    wait_ready();
    @(posedge clk);
    push_op(2'b10, 1'b1, 0);
    #1;
    req_valid = 1'b0;
    drain();

    // Reserved op: no strobe, done and err together.
    do_op(2'b11, 1'b1, 2'd2);
    drain();

    // Reset during the second RUN cycle of INC cnt=3.
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 1'b0;
    req_cnt   = 2'd3;
    @(posedge clk);
    push(v_run(2'b01, 1'b0), "rst_run0");
    push(v_run(2'b01, 1'b0), "rst_run1");
    push(V_IDLE, "rst_idle0");
    push(V_IDLE, "rst_idle1");
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drain();

`ifdef ALU_SEQ_ABORT_EN
    // Abort sampled in the second RUN cycle ends the op on the next edge.
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 1'b1;
    req_cnt   = 2'd3;
    @(posedge clk);
    push(v_run(2'b01, 1'b1), "ab_run0");
    push(v_run(2'b01, 1'b1), "ab_run1");
    push(V_DONE, "ab_done");
    push(V_IDLE, "ab_gap");
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();
`endif

    // A few more patterns, then random ops.
    do_op(2'b00, 1'b1, 2'd3);
    drain();
    do_op(2'b01, 1'b1, 2'd2);
    drain();
    for (int i = 0; i < 8; i++) begin
      do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      drain();
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
